// File: rtl/wb_arbiter_pkg.sv
// Shared types for the two-source register-file writeback arbiter.
// Source indices double as bit positions in the request/grant vectors.
package wb_arbiter_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 64;
  localparam int WB_CNT_WIDTH  = 64;

  typedef enum logic {
    WB_SRC_LSU = 1'b0,
    WB_SRC_ALU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  function automatic logic [1:0] wb_src_bit(input wb_src_e src);
    return 2'(2'b01 << src);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU and LSU valid/ready result offers in, register-file write port and retire count out.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
);

  logic                    alu_valid;
  logic [ADDR_WIDTH-1:0]   alu_rd;
  logic [DATA_WIDTH-1:0]   alu_data;
  logic                    alu_ready;

  logic                    lsu_valid;
  logic [ADDR_WIDTH-1:0]   lsu_rd;
  logic [DATA_WIDTH-1:0]   lsu_data;
  logic                    lsu_ready;

  logic                    wen;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [WB_CNT_WIDTH-1:0] retire_cnt;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output wen, waddr, wdata, retire_cnt
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  wen, waddr, wdata, retire_cnt
  );

endinterface

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-request round-robin arbiter: combinational grant, 1-bit pointer flips only on contention.
// Grants are forced low while reset is asserted.
module rr_arb2
  import wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  wb_src_e    r_ptr;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (rst_n) begin
      if (&i_req) begin
        w_gnt = wb_src_bit(r_ptr);
      end else begin
        w_gnt = i_req;
      end
    end
  end

  // Uncontested grants leave the pointer alone so the waiting order survives idle gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= WB_SRC_LSU;
    end else if (&i_req) begin
      r_ptr <= (r_ptr == WB_SRC_LSU) ? WB_SRC_ALU : WB_SRC_LSU;
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one ALU/LSU result accepted per cycle, written to the register file 1 cycle later.
// Losing source sees ready low and must hold its offer; writes to rd 0 are accepted and counted but suppressed.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave io_wb
);

  logic [1:0]              w_req;
  logic [1:0]              w_gnt;
  logic                    w_hs;
  logic                    w_wr;
  logic [ADDR_WIDTH-1:0]   w_sel_rd;
  logic [DATA_WIDTH-1:0]   w_sel_data;

  logic                    r_wen;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [WB_CNT_WIDTH-1:0] r_retire_cnt;

  assign w_req[WB_SRC_LSU] = io_wb.lsu_valid;
  assign w_req[WB_SRC_ALU] = io_wb.alu_valid;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign io_wb.lsu_ready = w_gnt[WB_SRC_LSU];
  assign io_wb.alu_ready = w_gnt[WB_SRC_ALU];

  always_comb begin
    w_sel_rd   = io_wb.lsu_rd;
    w_sel_data = io_wb.lsu_data;
    if (w_gnt[WB_SRC_ALU]) begin
      w_sel_rd   = io_wb.alu_rd;
      w_sel_data = io_wb.alu_data;
    end
  end

  assign w_hs = |w_gnt;
  assign w_wr = w_hs && (w_sel_rd != '0);

  // Address/data only move on a real write, so they hold through idle and rd-0 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen        <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_wen <= w_wr;
      if (w_wr) begin
        r_waddr <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
      if (w_hs) begin
        r_retire_cnt <= r_retire_cnt + 64'd1;
      end
    end
  end

  assign io_wb.wen        = r_wen;
  assign io_wb.waddr      = r_waddr;
  assign io_wb.wdata      = r_wdata;
  assign io_wb.retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change and are checked at posedge+1/+2, registered outputs at posedge+1.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [63:0] exp_cnt;

  wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

  wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_wb (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    bus.lsu_valid = v;
    bus.lsu_rd    = rd;
    bus.lsu_data  = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_alu(1'b1, 5'd1, 64'h1);
    set_lsu(1'b1, 5'd2, 64'h2);
    #2;
    n_cmp++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL reset_alu_ready got %b want 0", bus.alu_ready); end
    n_cmp++; if (bus.lsu_ready !== 1'b0) begin n_err++; $display("FAIL reset_lsu_ready got %b want 0", bus.lsu_ready); end
    cyc();
    cyc();
    n_cmp++; if (bus.wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b want 0", bus.wen); end
    n_cmp++; if (bus.waddr !== 5'd0) begin n_err++; $display("FAIL reset_waddr got %0d want 0", bus.waddr); end
    n_cmp++; if (bus.wdata !== 64'd0) begin n_err++; $display("FAIL reset_wdata got %h want 0", bus.wdata); end
    n_cmp++; if (bus.retire_cnt !== 64'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", bus.retire_cnt); end
    set_alu(1'b0, 5'd0, 64'h0);
    set_lsu(1'b0, 5'd0, 64'h0);
    rst_n   = 1'b1;
    exp_cnt = 64'd0;
    cyc();
  endtask

  // Pointer starts at LSU after reset.
  task automatic test_both_first();
    set_lsu(1'b1, 5'd5, 64'h11);
    set_alu(1'b1, 5'd6, 64'h22);
    #1;
    n_cmp++; if (bus.lsu_ready !== 1'b1) begin n_err++; $display("FAIL first_lsu_ready got %b want 1", bus.lsu_ready); end
    n_cmp++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL first_alu_wait got %b want 0", bus.alu_ready); end
    cyc();
    exp_cnt = 64'd1;
    n_cmp++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd5, 64'h11}) begin n_err++; $display("FAIL first_wr0 got %b/%0d/%h want 1/5/11", bus.wen, bus.waddr, bus.wdata); end
    n_cmp++; if (bus.retire_cnt !== exp_cnt) begin n_err++; $display("FAIL first_cnt0 got %0d want %0d", bus.retire_cnt, exp_cnt); end
    set_lsu(1'b0, 5'd0, 64'h0);
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL first_alu_ready got %b want 1", bus.alu_ready); end
    cyc();
    exp_cnt = 64'd2;
    n_cmp++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd6, 64'h22}) begin n_err++; $display("FAIL first_wr1 got %b/%0d/%h want 1/6/22", bus.wen, bus.waddr, bus.wdata); end
    n_cmp++; if (bus.retire_cnt !== exp_cnt) begin n_err++; $display("FAIL first_cnt1 got %0d want %0d", bus.retire_cnt, exp_cnt); end
    set_alu(1'b0, 5'd0, 64'h0);
    #1;
    n_cmp++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b00) begin n_err++; $display("FAIL idle_ready got %b want 00", {bus.alu_ready, bus.lsu_ready}); end
  endtask

  task automatic test_single_alu();
    cyc();
    set_alu(1'b1, 5'd3, 64'hAA);
    #1;
    n_cmp++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b10) begin n_err++; $display("FAIL alu_only_ready got %b want 10", {bus.alu_ready, bus.lsu_ready}); end
    cyc();
    exp_cnt = exp_cnt + 64'd1;
    n_cmp++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd3, 64'hAA}) begin n_err++; $display("FAIL alu_only_wr got %b/%0d/%h want 1/3/aa", bus.wen, bus.waddr, bus.wdata); end
    n_cmp++; if (bus.retire_cnt !== exp_cnt) begin n_err++; $display("FAIL alu_only_cnt got %0d want %0d", bus.retire_cnt, exp_cnt); end
    set_alu(1'b0, 5'd0, 64'h0);
    cyc();
    n_cmp++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b0, 5'd3, 64'hAA}) begin n_err++; $display("FAIL idle_hold got %b/%0d/%h want 0/3/aa", bus.wen, bus.waddr, bus.wdata); end
    n_cmp++; if (bus.retire_cnt !== exp_cnt) begin n_err++; $display("FAIL idle_cnt got %0d want %0d", bus.retire_cnt, exp_cnt); end
  endtask

  // Pointer is at ALU here (last contention was won by LSU).
  task automatic test_same_rd();
    set_alu(1'b1, 5'd7, 64'h1);
    set_lsu(1'b1, 5'd7, 64'h2);
    #1;
    n_cmp++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b10) begin n_err++; $display("FAIL same_rd_gnt0 got %b want 10", {bus.alu_ready, bus.lsu_ready}); end
    cyc();
    exp_cnt = exp_cnt + 64'd1;
    n_cmp++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd7, 64'h1}) begin n_err++; $display("FAIL same_rd_wr0 got %b/%0d/%h want 1/7/1", bus.wen, bus.waddr, bus.wdata); end
    set_alu(1'b0, 5'd0, 64'h0);
    #1;
    n_cmp++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b01) begin n_err++; $display("FAIL same_rd_gnt1 got %b want 01", {bus.alu_ready, bus.lsu_ready}); end
    cyc();
    exp_cnt = exp_cnt + 64'd1;
    n_cmp++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd7, 64'h2}) begin n_err++; $display("FAIL same_rd_wr1 got %b/%0d/%h want 1/7/2", bus.wen, bus.waddr, bus.wdata); end
    n_cmp++; if (bus.retire_cnt !== exp_cnt) begin n_err++; $display("FAIL same_rd_cnt got %0d want %0d", bus.retire_cnt, exp_cnt); end
    set_lsu(1'b0, 5'd0, 64'h0);
    cyc();
    n_cmp++; if ({bus.wen, bus.wdata} !== {1'b0, 64'h2}) begin n_err++; $display("FAIL same_rd_final got %b/%h want 0/2", bus.wen, bus.wdata); end
  endtask

  // Pointer is back at LSU; both sources stay valid and advance on their own ready.
  task automatic test_alternate();
    wb_req_t lsu_q [3];
    wb_req_t alu_q [3];
    logic    exp_alu [4];
    wb_req_t exp_wr  [4];
    int li;
    int ai;
    lsu_q   = '{'{5'd1, 64'h100}, '{5'd3, 64'h101}, '{5'd5, 64'h102}};
    alu_q   = '{'{5'd2, 64'h200}, '{5'd4, 64'h201}, '{5'd6, 64'h202}};
    exp_alu = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_wr  = '{'{5'd1, 64'h100}, '{5'd2, 64'h200}, '{5'd3, 64'h101}, '{5'd4, 64'h201}};
    li = 0;
    ai = 0;
    for (int i = 0; i < 4; i++) begin
      set_lsu(1'b1, lsu_q[li].rd, lsu_q[li].data);
      set_alu(1'b1, alu_q[ai].rd, alu_q[ai].data);
      #1;
      n_cmp++; if ({bus.alu_ready, bus.lsu_ready} !== {exp_alu[i], ~exp_alu[i]}) begin n_err++; $display("FAIL alt_gnt%0d got %b want %b", i, {bus.alu_ready, bus.lsu_ready}, {exp_alu[i], ~exp_alu[i]}); end
      if (bus.alu_ready) ai++;
      if (bus.lsu_ready) li++;
      cyc();
      exp_cnt = exp_cnt + 64'd1;
      n_cmp++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, exp_wr[i].rd, exp_wr[i].data}) begin n_err++; $display("FAIL alt_wr%0d got %b/%0d/%h want 1/%0d/%h", i, bus.wen, bus.waddr, bus.wdata, exp_wr[i].rd, exp_wr[i].data); end
    end
    n_cmp++; if (bus.retire_cnt !== exp_cnt) begin n_err++; $display("FAIL alt_cnt got %0d want %0d", bus.retire_cnt, exp_cnt); end
    set_lsu(1'b0, 5'd0, 64'h0);
    set_alu(1'b0, 5'd0, 64'h0);
  endtask

  task automatic test_rd_zero();
    set_lsu(1'b1, 5'd0, 64'hFF);
    #1;
    n_cmp++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b01) begin n_err++; $display("FAIL rd0_ready got %b want 01", {bus.alu_ready, bus.lsu_ready}); end
    cyc();
    exp_cnt = exp_cnt + 64'd1;
    n_cmp++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b0, 5'd4, 64'h201}) begin n_err++; $display("FAIL rd0_wr got %b/%0d/%h want 0/4/201", bus.wen, bus.waddr, bus.wdata); end
    n_cmp++; if (bus.retire_cnt !== exp_cnt) begin n_err++; $display("FAIL rd0_cnt got %0d want %0d", bus.retire_cnt, exp_cnt); end
    set_lsu(1'b0, 5'd0, 64'h0);
  endtask

  task automatic test_reset_mid();
    set_alu(1'b1, 5'd9, 64'h55);
    #1;
    cyc();
    exp_cnt = exp_cnt + 64'd1;
    n_cmp++; if ({bus.wen, bus.waddr} !== {1'b1, 5'd9}) begin n_err++; $display("FAIL mid_wr got %b/%0d want 1/9", bus.wen, bus.waddr); end
    set_alu(1'b1, 5'd10, 64'h66);
    #1;
    n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL mid_pending_ready got %b want 1", bus.alu_ready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b0, 5'd0, 64'h0}) begin n_err++; $display("FAIL mid_rst_out got %b/%0d/%h want 0/0/0", bus.wen, bus.waddr, bus.wdata); end
    n_cmp++; if (bus.retire_cnt !== 64'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d want 0", bus.retire_cnt); end
    n_cmp++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready got %b want 0", bus.alu_ready); end
    cyc();
    n_cmp++; if ({bus.wen, bus.retire_cnt} !== {1'b0, 64'd0}) begin n_err++; $display("FAIL mid_discard got %b/%0d want 0/0", bus.wen, bus.retire_cnt); end
    set_alu(1'b0, 5'd0, 64'h0);
    rst_n   = 1'b1;
    exp_cnt = 64'd0;
    cyc();
    set_alu(1'b1, 5'd12, 64'h77);
    #1;
    n_cmp++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b10) begin n_err++; $display("FAIL post_rst_ready got %b want 10", {bus.alu_ready, bus.lsu_ready}); end
    cyc();
    exp_cnt = exp_cnt + 64'd1;
    n_cmp++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd12, 64'h77}) begin n_err++; $display("FAIL post_rst_wr got %b/%0d/%h want 1/12/77", bus.wen, bus.waddr, bus.wdata); end
    n_cmp++; if (bus.retire_cnt !== exp_cnt) begin n_err++; $display("FAIL post_rst_cnt got %0d want %0d", bus.retire_cnt, exp_cnt); end
    set_alu(1'b0, 5'd0, 64'h0);
    cyc();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_cnt = 64'd0;
    test_reset();
    test_both_first();
    test_single_alu();
    test_same_rd();
    test_alternate();
    test_rd_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
